rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Reset release sequencer that sits directly downstream of the per-domain reset synchronizer.
- Consumes the synchronized active-low reset as its own async reset, then releases NUM_STG downstream stage resets one at a time in fixed order 0..NUM_STG-1.
- Between releases it inserts a programmable gap and waits for a per-stage ready acknowledge, with a bounded timeout.
- Supports a software-requested full re-sequence, and a scan-mode bypass for DFT.

Parameters:
- NUM_STG, 4: number of sequenced stage resets; legal range 2..16.
- HOLD_CYC, 16: cycles all stage resets stay asserted after reset or a software request; must be >= 1.
- DLY_CYC, 8: gap cycles before each stage release; must be >= 1.
- TO_CYC, 256: maximum cycles to wait for a stage acknowledge; must be >= 1.
- IDX_W, $clog2(NUM_STG): stage index width.

Ports:
- i_clk  in  1  sequencer clock.
- dft_rstn  in  1  async active-low reset.
- i_scan_mode  in  1  scan bypass: all o_stg_rstn follow dft_rstn combinationally.
- i_sw_rst_req  in  1  single-cycle software re-sequence request, synchronous to i_clk.
- i_stg_ack  in  NUM_STG  per-stage ready acknowledge, synchronous to i_clk, level-sensitive.
- o_stg_rstn  out  NUM_STG  per-stage active-low resets, registered (except in scan bypass).
- o_seq_busy  out  1  high while the sequence is not complete.
- o_seq_done  out  1  high once every stage has been released.
- o_stg_idx  out  IDX_W  stage currently being processed.
- o_to_err  out  NUM_STG  sticky per-stage acknowledge-timeout flags.

Behaviour:
- Reset is dft_rstn, asynchronous, active-low; clock is i_clk. All state is async-reset by dft_rstn.
- Reset values:
  - o_stg_rstn = 0
  - o_seq_busy = 1
  - o_seq_done = 0
  - o_stg_idx = 0
  - o_to_err = 0
  - internal counter = 0
  - state = S_HOLD
- Edge numbering: edge n = nth rising edge of i_clk after dft_rstn deasserts.
- S_HOLD:
  - Counter increments each cycle.
  - When cnt == HOLD_CYC-1: clear cnt, go to S_DLY.
- S_DLY:
  - Counter increments each cycle.
  - When cnt == DLY_CYC-1: set o_stg_rstn[o_stg_idx] = 1, clear cnt, go to S_ACK.
  - Stage release lands on edge HOLD_CYC+DLY_CYC for stage 0.
- S_ACK:
  - If i_stg_ack[o_stg_idx] == 1: advance.
  - Else if cnt == TO_CYC-1: set o_to_err[o_stg_idx] = 1, then advance.
  - Else: cnt++.
  - Advance means: clear cnt; if o_stg_idx == NUM_STG-1 go to S_DONE, else o_stg_idx++ and go to S_DLY.
- S_DONE:
  - o_seq_busy = 0, o_seq_done = 1, registered on the same edge as the transition into S_DONE.
  - o_stg_idx holds NUM_STG-1.
- Acknowledge rules:
  - Acks are sampled only in S_ACK and only for the current index; acks on other bits are ignored.
  - An ack already high on the first S_ACK cycle advances on the next edge.
  - Once a stage is released it stays released until a software request or dft_rstn.
- i_sw_rst_req, honoured in any state, takes priority over ack, timeout and counter terminal conditions in the same cycle. On the next edge:
  - all o_stg_rstn = 0
  - o_seq_done = 0, o_seq_busy = 1
  - o_stg_idx = 0, cnt = 0
  - state = S_HOLD (a request while in S_HOLD restarts the hold count)
- o_to_err is cleared only by dft_rstn; i_sw_rst_req does not clear it.
- Scan mode:
  - i_scan_mode = 1 forces o_stg_rstn = {NUM_STG{dft_rstn}}.
  - The FSM keeps running; the other outputs are unaffected.
- Counter width: sized for max(HOLD_CYC, DLY_CYC, TO_CYC); no wrap is possible.
- dft_rstn asserted mid-sequence: all outputs return to their reset values immediately (async).

Test Plan:
- Defaults, acks tied high, deassert dft_rstn -> o_stg_rstn[0..3] rise at edges 24, 33, 42, 51; o_seq_done = 1 and o_seq_busy = 0 at edge 52; o_to_err = 0.
- Acks tied low -> stage 0 rises at edge 24; o_to_err[0] = 1 at edge 280; stage 1 rises at edge 288; final o_to_err = 4'hF.
- i_stg_ack[2] pulsed while o_stg_idx = 1 -> ignored; stage 1 still waits for its own ack or times out.
- After done, pulse i_sw_rst_req -> all o_stg_rstn = 0 and o_seq_done = 0 on next edge; full sequence repeats with the same relative timing; o_to_err retained.
- i_sw_rst_req in the same cycle as i_stg_ack[idx] in S_ACK -> software request wins, state S_HOLD, o_stg_idx = 0.
- i_scan_mode = 1 with FSM in S_HOLD -> o_stg_rstn = 4'hF while dft_rstn = 1, and 4'h0 immediately when dft_rstn = 0.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Purpose:
//   Reset release sequencer placed directly after a per-domain reset
//   synchronizer. While dft_rstn is low every stage reset is held. After
//   dft_rstn releases, all stages stay held for HOLD_CYC cycles. The stages
//   are then released one at a time in order 0..NUM_STG-1. Each release is
//   preceded by a DLY_CYC-cycle gap and followed by a wait for that stage's
//   ready acknowledge. The wait is bounded by TO_CYC cycles, and an expired
//   wait raises a sticky per-stage timeout flag.
//
//   A single-cycle software request re-runs the whole sequence from the hold
//   phase. Scan mode bypasses the registered stage resets so that they follow
//   dft_rstn directly.
//
// Ports:
//   i_clk         sequencer clock
//   dft_rstn      asynchronous active-low reset for all state
//   i_scan_mode   1: o_stg_rstn = {NUM_STG{dft_rstn}} (the FSM keeps running)
//   i_sw_rst_req  single-cycle request to restart the full sequence
//   i_stg_ack     per-stage ready acknowledge (level, sampled for the
//                 current stage only)
//   o_stg_rstn    per-stage active-low resets
//   o_seq_busy    high until every stage has been released
//   o_seq_done    high once every stage has been released
//   o_stg_idx     index of the stage currently being processed
//   o_to_err      sticky per-stage acknowledge-timeout flags
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int NUM_STG  = 4,
  parameter int HOLD_CYC = 16,
  parameter int DLY_CYC  = 8,
  parameter int TO_CYC   = 256,
  parameter int IDX_W    = $clog2(NUM_STG)
) (
  input  logic               i_clk,
  input  logic               dft_rstn,
  input  logic               i_scan_mode,
  input  logic               i_sw_rst_req,
  input  logic [NUM_STG-1:0] i_stg_ack,
  output logic [NUM_STG-1:0] o_stg_rstn,
  output logic               o_seq_busy,
  output logic               o_seq_done,
  output logic [IDX_W-1:0]   o_stg_idx,
  output logic [NUM_STG-1:0] o_to_err
);

  // The counter only has to reach the largest terminal value, which is
  // MAX_CYC-1. The counter never counts past its terminal value, so it
  // cannot wrap.
  localparam int MAX_HD  = (HOLD_CYC > DLY_CYC) ? HOLD_CYC : DLY_CYC;
  localparam int MAX_CYC = (MAX_HD > TO_CYC) ? MAX_HD : TO_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DLY_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STG - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_DLY  = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt;
  logic [NUM_STG-1:0] r_stg_rstn;
  logic [NUM_STG-1:0] w_stg_rstn;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_STG-1:0] r_to_err;
  logic [NUM_STG-1:0] w_to_err;
  logic               r_busy;
  logic               w_busy;
  logic               r_done;
  logic               w_done;
  logic               w_ack_cur;

  // Only the acknowledge of the stage being processed matters.
  assign w_ack_cur = i_stg_ack[r_idx];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge dft_rstn) begin
    if (!dft_rstn) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_stg_rstn <= '0;
      r_idx      <= '0;
      r_to_err   <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_stg_rstn <= w_stg_rstn;
      r_idx      <= w_idx;
      r_to_err   <= w_to_err;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_stg_rstn = r_stg_rstn;
    w_idx      = r_idx;
    w_to_err   = r_to_err;
    w_busy     = r_busy;
    w_done     = r_done;

    if (i_sw_rst_req) begin
      // A software request overrides every other condition in this cycle.
      // The timeout history is kept because it is a diagnostic record.
      w_state    = S_HOLD;
      w_cnt      = '0;
      w_stg_rstn = '0;
      w_idx      = '0;
      w_busy     = 1'b1;
      w_done     = 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_cnt   = '0;
            w_state = S_DLY;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        S_DLY: begin
          if (r_cnt == DLY_LAST) begin
            w_stg_rstn[r_idx] = 1'b1;
            w_cnt             = '0;
            w_state           = S_ACK;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        S_ACK: begin
          if (w_ack_cur || (r_cnt == TO_LAST)) begin
            // An ack on the terminal cycle counts as an ack, not a timeout.
            if (!w_ack_cur) begin
              w_to_err[r_idx] = 1'b1;
            end
            w_cnt = '0;
            if (r_idx == IDX_LAST) begin
              w_state = S_DONE;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_idx   = r_idx + 1'b1;
              w_state = S_DLY;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          w_state = S_DONE;
        end

        default: begin
          w_state = S_HOLD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. In scan mode each stage reset follows dft_rstn through logic
  // only, so that the scan controller has direct control of the downstream
  // resets.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STG; gi++) begin : g_stg_out
      assign o_stg_rstn[gi] = i_scan_mode ? dft_rstn : r_stg_rstn[gi];
    end
  endgenerate

  assign o_seq_busy = r_busy;
  assign o_seq_done = r_done;
  assign o_stg_idx  = r_idx;
  assign o_to_err   = r_to_err;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Purpose:
//   Self-checking bench for rst_seq_ctrl with the default parameters.
//   Expected output snapshots are tagged with an edge number, which counts
//   rising edges of the clock after dft_rstn deasserts. The snapshots are
//   queued before the stimulus that produces them, and each one is compared
//   1 time unit after its edge. Asynchronous behaviour is checked directly.
//
// Ports: none.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int NUM_STG = 4;
  localparam int IDX_W   = 2;

  logic               clk;
  logic               dft_rstn;
  logic               scan_mode;
  logic               sw_req;
  logic [NUM_STG-1:0] stg_ack;
  logic [NUM_STG-1:0] stg_rstn;
  logic               seq_busy;
  logic               seq_done;
  logic [IDX_W-1:0]   stg_idx;
  logic [NUM_STG-1:0] to_err;

  rst_seq_ctrl #(
    .NUM_STG (4),
    .HOLD_CYC(16),
    .DLY_CYC (8),
    .TO_CYC  (256)
  ) dut (
    .i_clk       (clk),
    .dft_rstn    (dft_rstn),
    .i_scan_mode (scan_mode),
    .i_sw_rst_req(sw_req),
    .i_stg_ack   (stg_ack),
    .o_stg_rstn  (stg_rstn),
    .o_seq_busy  (seq_busy),
    .o_seq_done  (seq_done),
    .o_stg_idx   (stg_idx),
    .o_to_err    (to_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      nm;
    int         edge_n;
    logic [3:0] rstn;
    logic       busy;
    logic       done;
    logic [1:0] idx;
    logic [3:0] terr;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   edge_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end else begin
      $display("ok   %s value=%h", nm, act);
    end
  endtask

  task automatic push(input string nm, input int e, input logic [3:0] r, input logic b,
                      input logic d, input logic [1:0] i, input logic [3:0] t);
    exp_t x;
    x.nm = nm; x.edge_n = e; x.rstn = r; x.busy = b; x.done = d; x.idx = i; x.terr = t;
    sb_q.push_back(x);
  endtask

  // Advance one clock. Any queued expectation that is due is checked
  // 1 time unit after the edge.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    if (!dft_rstn) edge_cnt = 0;
    else edge_cnt++;
    #1;
    while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_cnt) begin
      x = sb_q.pop_front();
      if (x.edge_n < edge_cnt) begin
        checks++;
        errors++;
        $display("FAIL %s edge %0d missed (now edge %0d)", x.nm, x.edge_n, edge_cnt);
      end else begin
        chk($sformatf("%s@edge%0d {rstn,busy,done,idx,terr}", x.nm, x.edge_n),
            {20'd0, stg_rstn, seq_busy, seq_done, stg_idx, to_err},
            {20'd0, x.rstn, x.busy, x.done, x.idx, x.terr});
      end
    end
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  // Run until every queued expectation is checked. Anything still queued
  // when the cycle budget runs out is reported as a failure.
  task automatic drain();
    int guard;
    exp_t x;
    guard = 0;
    while (sb_q.size() > 0 && guard < 3000) begin
      tick();
      guard++;
    end
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s edge %0d never reached (timeout)", x.nm, x.edge_n);
    end
  endtask

  task automatic pulse_req();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
  endtask

  exp_t tab_a[8];

  initial begin
    checks    = 0;
    errors    = 0;
    edge_cnt  = 0;
    scan_mode = 1'b0;
    sw_req    = 1'b0;
    stg_ack   = 4'h0;
    dft_rstn  = 1'b1;
    #3 dft_rstn = 1'b0;
    #1;

    // ---- reset state ----
    chk("reset_rstn", {28'd0, stg_rstn}, 32'h0);
    chk("reset_busy_done_idx", {28'd0, seq_busy, seq_done, stg_idx}, {28'd0, 1'b1, 1'b0, 2'd0});
    chk("reset_to_err", {28'd0, to_err}, 32'h0);
    repeat (3) tick();

    // ---- A: acks tied high, nominal release timing ----
    tab_a[0] = '{"A_hold",  23, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0};
    tab_a[1] = '{"A_stg0",  24, 4'h1, 1'b1, 1'b0, 2'd0, 4'h0};
    tab_a[2] = '{"A_pre1",  32, 4'h1, 1'b1, 1'b0, 2'd1, 4'h0};
    tab_a[3] = '{"A_stg1",  33, 4'h3, 1'b1, 1'b0, 2'd1, 4'h0};
    tab_a[4] = '{"A_stg2",  42, 4'h7, 1'b1, 1'b0, 2'd2, 4'h0};
    tab_a[5] = '{"A_stg3",  51, 4'hF, 1'b1, 1'b0, 2'd3, 4'h0};
    tab_a[6] = '{"A_done",  52, 4'hF, 1'b0, 1'b1, 2'd3, 4'h0};
    tab_a[7] = '{"A_hold2", 60, 4'hF, 1'b0, 1'b1, 2'd3, 4'h0};
    stg_ack = 4'hF;
    for (int i = 0; i < 8; i++) sb_q.push_back(tab_a[i]);
    dft_rstn = 1'b1;
    drain();

    // ---- B: acks tied low, every stage times out; foreign ack ignored ----
    dft_rstn = 1'b0;
    stg_ack  = 4'h0;
    repeat (2) tick();
    push("B_stg0",    24,   4'h1, 1'b1, 1'b0, 2'd0, 4'h0);
    push("B_preto0",  279,  4'h1, 1'b1, 1'b0, 2'd0, 4'h0);
    push("B_to0",     280,  4'h1, 1'b1, 1'b0, 2'd1, 4'h1);
    push("B_pre1",    287,  4'h1, 1'b1, 1'b0, 2'd1, 4'h1);
    push("B_stg1",    288,  4'h3, 1'b1, 1'b0, 2'd1, 4'h1);
    push("B_ign2",    302,  4'h3, 1'b1, 1'b0, 2'd1, 4'h1);
    push("B_preto1",  543,  4'h3, 1'b1, 1'b0, 2'd1, 4'h1);
    push("B_to1",     544,  4'h3, 1'b1, 1'b0, 2'd2, 4'h3);
    push("B_stg2",    552,  4'h7, 1'b1, 1'b0, 2'd2, 4'h3);
    push("B_stg3",    816,  4'hF, 1'b1, 1'b0, 2'd3, 4'h7);
    push("B_done",    1072, 4'hF, 1'b0, 1'b1, 2'd3, 4'hF);
    dft_rstn = 1'b1;
    run_to(300);
    stg_ack = 4'b0100;   // sampled on edge 301 while stage 1 is waiting
    tick();
    stg_ack = 4'h0;
    drain();

    // ---- C: software re-sequence after done keeps the timeout flags ----
    push("C_req",    1081, 4'h0, 1'b1, 1'b0, 2'd0, 4'hF);
    push("C_hold",   1104, 4'h0, 1'b1, 1'b0, 2'd0, 4'hF);
    push("C_stg0",   1105, 4'h1, 1'b1, 1'b0, 2'd0, 4'hF);
    push("C_stg1",   1114, 4'h3, 1'b1, 1'b0, 2'd1, 4'hF);
    push("C_stg2",   1123, 4'h7, 1'b1, 1'b0, 2'd2, 4'hF);
    push("C_stg3",   1132, 4'hF, 1'b1, 1'b0, 2'd3, 4'hF);
    push("C_done",   1133, 4'hF, 1'b0, 1'b1, 2'd3, 4'hF);
    run_to(1080);
    stg_ack = 4'hF;
    pulse_req();
    drain();

    // ---- D: request beats ack in S_ACK; request in S_HOLD restarts hold ----
    push("D_req",     1140, 4'h0, 1'b1, 1'b0, 2'd0, 4'hF);
    push("D_stg0",    1164, 4'h1, 1'b1, 1'b0, 2'd0, 4'hF);
    push("D_win",     1165, 4'h0, 1'b1, 1'b0, 2'd0, 4'hF);
    push("D_win2",    1166, 4'h0, 1'b1, 1'b0, 2'd0, 4'hF);
    push("D_rehold",  1189, 4'h0, 1'b1, 1'b0, 2'd0, 4'hF);
    push("D_rehold2", 1193, 4'h0, 1'b1, 1'b0, 2'd0, 4'hF);
    push("D_stg0b",   1194, 4'h1, 1'b1, 1'b0, 2'd0, 4'hF);
    run_to(1139);
    pulse_req();          // acts on edge 1140
    run_to(1164);
    pulse_req();          // edge 1165, ack[0] is high in the same cycle
    run_to(1169);
    pulse_req();          // edge 1170, in S_HOLD
    drain();

    // ---- E: async reset mid-sequence, then scan bypass in S_HOLD ----
    run_to(1200);
    #2 dft_rstn = 1'b0;
    #1;
    chk("async_rst_rstn", {28'd0, stg_rstn}, 32'h0);
    chk("async_rst_busy_done_idx", {28'd0, seq_busy, seq_done, stg_idx}, {28'd0, 1'b1, 1'b0, 2'd0});
    chk("async_rst_to_err", {28'd0, to_err}, 32'h0);
    repeat (2) tick();
    dft_rstn = 1'b1;
    run_to(5);
    scan_mode = 1'b1;
    #1;
    chk("scan_rstn_high", {28'd0, stg_rstn}, 32'hF);
    chk("scan_busy_done", {30'd0, seq_busy, seq_done}, {30'd0, 1'b1, 1'b0});
    dft_rstn = 1'b0;
    #1;
    chk("scan_rstn_low", {28'd0, stg_rstn}, 32'h0);
    scan_mode = 1'b0;
    dft_rstn  = 1'b1;
    #1;
    chk("noscan_rstn_held", {28'd0, stg_rstn}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
